// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and limits for the clock time-keeping block
// Contents: set-mode state encoding, field maxima, wrap-increment helper.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_e;

  localparam logic [4:0] MAX_HR  = 5'd23;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_SEC = 6'd59;

  // Increment a 6-bit time field, wrapping to 0 after max.
  function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hours(input logic [4:0] v);
    return (v == MAX_HR) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_tick_gen.sv
// rtl/clock_time_ctrl_tick_gen.sv - prescaler producing 1 Hz and half-second strobes
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   clr        : synchronous clear of the prescaler and both strobes
//   sec_tick   : one-cycle strobe, the cycle after the prescaler holds CLK_HZ-1
//   half_tick  : one-cycle strobe, the cycle after the prescaler holds CLK_HZ/2-1
module tick_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic sec_tick,
  output logic half_tick
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_HZ / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sec_tick_q, sec_tick_d;
  logic             half_tick_q, half_tick_d;

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    sec_tick_d  = 1'b0;
    half_tick_d = 1'b0;
    if (clr) begin
      // A strobe pending at the clear edge is dropped so the next
      // second is a full CLK_HZ cycles away.
      cnt_d = '0;
    end else begin
      if (cnt_q == LAST) begin
        cnt_d      = '0;
        sec_tick_d = 1'b1;
      end
      half_tick_d = (cnt_q == HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sec_tick_q  <= 1'b0;
      half_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sec_tick_q  <= sec_tick_d;
      half_tick_q <= half_tick_d;
    end
  end

  assign sec_tick  = sec_tick_q;
  assign half_tick = half_tick_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - HH:MM:SS time keeping with button-driven set mode
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   btn_mode, btn_inc : debounced single-cycle button pulses
//   hours/minutes/seconds : registered binary time fields
//   set_mode          : 00 RUN, 01 SET_HR, 10 SET_MIN
//   blink             : blank-enable for the field being set, 0 in RUN
//   sec_tick          : registered 1 Hz strobe
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] set_mode,
  output logic       blink,
  output logic       sec_tick
);

  state_e     state_q, state_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;
  logic       blink_q, blink_d;
  logic       clr;
  logic       tick;
  logic       half_tick;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .sec_tick (tick),
    .half_tick(half_tick)
  );

  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    blink_d   = blink_q;
    clr       = 1'b0;
    unique case (state_q)
      RUN: begin
        blink_d = 1'b0;
        // Time still advances on the tick that coincides with btn_mode.
        if (tick) begin
          seconds_d = inc_wrap6(seconds_q, MAX_SEC);
          if (seconds_q == MAX_SEC) begin
            minutes_d = inc_wrap6(minutes_q, MAX_MIN);
            if (minutes_q == MAX_MIN) begin
              hours_d = inc_hours(hours_q);
            end
          end
        end
        if (btn_mode) begin
          state_d = SET_HR;
          blink_d = 1'b1;
        end
      end
      SET_HR: begin
        if (btn_mode) begin
          state_d = SET_MIN;
          blink_d = 1'b1;
        end else begin
          if (btn_inc) hours_d = inc_hours(hours_q);
          if (tick || half_tick) blink_d = ~blink_q;
        end
      end
      SET_MIN: begin
        if (btn_mode) begin
          // Restart the second from zero so the first tick after setting
          // lands a full second later.
          state_d   = RUN;
          blink_d   = 1'b0;
          seconds_d = '0;
          clr       = 1'b1;
        end else begin
          if (btn_inc) minutes_d = inc_wrap6(minutes_q, MAX_MIN);
          if (tick || half_tick) blink_d = ~blink_q;
        end
      end
      default: begin
        state_d = RUN;
        blink_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      blink_q   <= blink_d;
    end
  end

  assign hours    = hours_q;
  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign set_mode = state_q;
  assign blink    = blink_q;
  assign sec_tick = tick;

endmodule
